// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the 8N1 UART receiver: the
//                bit-level state encoding and the clocks-per-bit calculation.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Bit-level receiver states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_t;

    // System clocks per serial bit, truncating integer division
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_byte
//  Description : 2-flop synchroniser plus bit-level 8N1 receive FSM. Emits
//                one accepted byte with a single-cycle byte_valid strobe.
//                Macro UART_RX_FRAME_ERR_EN adds a frame_err strobe output.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int boadrate = 115200
) (
    input  logic       clk,
    input  logic       arstn,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int c_clks_per_bit = clks_per_bit(CLK_FREQ, boadrate);
    localparam int c_half_bit     = c_clks_per_bit / 2;
    localparam int c_cnt_w        = $clog2(c_clks_per_bit) + 1;

    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half_bit - 1);

    logic               r_rx_meta;
    logic               r_rx_s;
    uart_state_t        r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [7:0]         r_byte;
    logic               r_byte_valid;
`ifdef UART_RX_FRAME_ERR_EN
    logic               r_frame_err;
`endif

    // Bring the asynchronous line into the clock domain; idle level is 1
    always_ff @(posedge clk) begin
        if (arstn) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Frame FSM: find start edge, confirm at mid-start, sample mid-bit
    always_ff @(posedge clk) begin
        if (arstn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_frame_err  <= 1'b0;
`endif
        end else begin
            r_byte_valid <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            r_frame_err  <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        // A high line at mid-start is a glitch, not a frame
                        r_state   <= r_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
`ifdef UART_RX_FRAME_ERR_EN
                            r_frame_err <= 1'b1;
`endif
                            r_state     <= WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // Line stuck low after a bad stop bit: wait for release
                    if (r_rx_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rx_byte    = r_byte;
    assign byte_valid = r_byte_valid;
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err  = r_frame_err;
`endif

endmodule : uart_rx_byte
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver that packs DEPTH consecutive bytes into
//                one word (first byte in data[0]) and strobes valid once per
//                word. Macro UART_RX_FRAME_ERR_EN adds a frame_err output
//                and drops the partially packed word on a framing error.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int boadrate = 115200,
    parameter int DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  rx,
    output logic [DEPTH-1:0][7:0] data,
    output logic                  valid
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic                  frame_err
`endif
);

    localparam int c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DEPTH - 1);

    logic [7:0]            w_byte;
    logic                  w_byte_valid;
`ifdef UART_RX_FRAME_ERR_EN
    logic                  w_frame_err;
`endif

    logic [DEPTH-1:0][7:0] r_data;
    logic [c_idx_w-1:0]    r_idx;
    logic                  r_valid;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .boadrate (boadrate)
    ) u_byte (
        .clk        (clk),
        .arstn      (arstn),
        .rx         (rx),
        .rx_byte    (w_byte),
        .byte_valid (w_byte_valid)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err  (w_frame_err)
`endif
    );

    // Drop each accepted byte into its slot; strobe valid on the last slot
    always_ff @(posedge clk) begin
        if (arstn) begin
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_byte_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_idx == c_idx_w'(i)) begin
                        r_data[i] <= w_byte;
                    end
                end
                if (r_idx == c_idx_last) begin
                    r_valid <= 1'b1;
                    r_idx   <= '0;
                end else begin
                    r_idx <= r_idx + c_idx_w'(1);
                end
            end
`ifdef UART_RX_FRAME_ERR_EN
            // A corrupted byte poisons the word being assembled
            if (w_frame_err) begin
                r_idx <= '0;
            end
`endif
        end
    end

    assign data  = r_data;
    assign valid = r_valid;
`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = w_frame_err;
`endif

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx: a DEPTH=4 instance and a
//                DEPTH=1 instance driven with directed 8N1 frames; expected
//                words are queued as frames are sent and popped on valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    localparam int c_clk_freq = 50_000_000;
    localparam int c_baud     = 1_000_000;
    localparam int c_cpb      = c_clk_freq / c_baud;

    logic             clk = 1'b0;
    logic             arstn = 1'b1;
    logic             rx4 = 1'b1;
    logic             rx1 = 1'b1;
    logic [3:0][7:0]  data4;
    logic             valid4;
    logic [0:0][7:0]  data1;
    logic             valid1;
`ifdef UART_RX_FRAME_ERR_EN
    logic             ferr4;
    logic             ferr1;
`endif

    int          checks = 0;
    int          errors = 0;
    int          n_valid4 = 0;
    int          n_valid1 = 0;
    int          n_ferr4 = 0;
    logic        in_stop4 = 1'b0;
    logic [31:0] q4[$];
    logic [7:0]  q1[$];

    always #10 clk = ~clk;

    uart_rx #(.CLK_FREQ(c_clk_freq), .boadrate(c_baud), .DEPTH(4)) u_dut4 (
        .clk   (clk),
        .arstn (arstn),
        .rx    (rx4),
        .data  (data4),
        .valid (valid4)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (ferr4)
`endif
    );

    uart_rx #(.CLK_FREQ(c_clk_freq), .boadrate(c_baud), .DEPTH(1)) u_dut1 (
        .clk   (clk),
        .arstn (arstn),
        .rx    (rx1),
        .data  (data1),
        .valid (valid1)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err (ferr1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        if (sel == 0) rx4 = v;
        else          rx1 = v;
    endtask

    task automatic send_bit(input int sel, input logic v);
        set_line(sel, v);
        repeat (c_cpb) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] b, input bit stop_ok);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, b[i]);
        if (sel == 0) in_stop4 = 1'b1;
        send_bit(sel, stop_ok ? 1'b1 : 1'b0);
        in_stop4 = 1'b0;
        set_line(sel, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        q4.push_back(w);
        for (int i = 0; i < 4; i++) send_frame(0, w[8*i +: 8], 1'b1);
    endtask

    initial begin
        // Output monitor / scoreboard consumer
        fork
            begin
                logic prev4 = 1'b0;
                logic prev1 = 1'b0;
                logic [31:0] e4;
                logic [7:0]  e1;
                forever begin
                    @(posedge clk);
                    #1;
                    if (valid4) begin
                        n_valid4++;
                        chk("v4_single", {31'd0, prev4}, 32'd0);
                        chk("v4_in_stop_bit", {31'd0, in_stop4}, 32'd1);
                        chk("v4_expected", q4.size(), 32'd1);
                        if (q4.size() > 0) begin
                            e4 = q4.pop_front();
                            chk("data4", data4, e4);
                        end
                    end
                    if (valid1) begin
                        n_valid1++;
                        chk("v1_single", {31'd0, prev1}, 32'd0);
                        chk("v1_expected", q1.size(), 32'd1);
                        if (q1.size() > 0) begin
                            e1 = q1.pop_front();
                            chk("data1", {24'd0, data1}, {24'd0, e1});
                        end
                    end
`ifdef UART_RX_FRAME_ERR_EN
                    if (ferr4) n_ferr4++;
`endif
                    prev4 = valid4;
                    prev1 = valid1;
                end
            end
        join_none

        // 1. Reset and idle line
        repeat (3) @(negedge clk);
        arstn = 1'b0;
        chk("rst_data4", data4, 32'd0);
        chk("rst_valid4", {31'd0, valid4}, 32'd0);
        chk("rst_data1", {24'd0, data1}, 32'd0);
        chk("rst_valid1", {31'd0, valid1}, 32'd0);
        repeat (10 * c_cpb) @(negedge clk);
        chk("idle_nvalid4", n_valid4, 0);
        chk("idle_nvalid1", n_valid1, 0);

        // 2. Four back-to-back frames
        send_word(32'hF0F0F055);
        repeat (c_cpb) @(negedge clk);
        chk("word1_count", n_valid4, 1);

        // 3. Short glitch while idle, then a full word
        rx4 = 1'b0;
        repeat (2) @(negedge clk);
        rx4 = 1'b1;
        repeat (3 * c_cpb) @(negedge clk);
        chk("glitch_nvalid4", n_valid4, 1);
        send_word(32'h12345678);
        repeat (c_cpb) @(negedge clk);
        chk("word2_count", n_valid4, 2);

        // 4. Framing error then good frames
        send_frame(0, 8'h33, 1'b0);
        repeat (2 * c_cpb) @(negedge clk);
        chk("ferr_nvalid4", n_valid4, 2);
`ifdef UART_RX_FRAME_ERR_EN
        chk("ferr_pulses", n_ferr4, 1);
`endif
        send_word(32'hDEADBEEF);
        repeat (c_cpb) @(negedge clk);
        chk("word3_count", n_valid4, 3);

        // 5. Reset after two bytes discards the partial word
        send_frame(0, 8'hAA, 1'b1);
        send_frame(0, 8'hBB, 1'b1);
        arstn = 1'b1;
        repeat (3) @(negedge clk);
        arstn = 1'b0;
        chk("midrst_data4", data4, 32'd0);
        send_word(32'h04030201);
        repeat (c_cpb) @(negedge clk);
        chk("word4_count", n_valid4, 4);

        // 6. DEPTH=1: every frame is a word
        q1.push_back(8'hA5);
        send_frame(1, 8'hA5, 1'b1);
        q1.push_back(8'h3C);
        send_frame(1, 8'h3C, 1'b1);

        // Drain with a bounded wait
        for (int i = 0; i < 20 * c_cpb; i++) begin
            if (q4.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        chk("q4_drained", q4.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("total_valid4", n_valid4, 4);
        chk("total_valid1", n_valid1, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
